// File: rtl/core_pkg.sv
// core_pkg: shared branch types, counter encoding and counter update helper
package core_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {COND = 2'b00, UNCOND = 2'b01, CALL = 2'b10, RET = 2'b11} br_type_t;
  typedef enum logic [1:0] {STRONG_NT = 2'b00, WEAK_NT = 2'b01, WEAK_T = 2'b10, STRONG_T = 2'b11} ctr_t;
  function automatic ctr_t ctr_next(input ctr_t c, input logic t);
    return t ? (c == STRONG_T ? c : ctr_t'(c + 2'd1)) : (c == STRONG_NT ? c : ctr_t'(c - 2'd1));
  endfunction
endpackage

// File: rtl/bp_ras.sv
// bp_ras: circular return-address stack with checkpoint restore followed by push/pop
module bp_ras #(
  parameter int XLEN = 32,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_restore,
  input  logic [PTR_W+CNT_W-1:0] i_restore_ckpt,
  input  logic [XLEN-1:0]        i_push_addr,
  output logic [XLEN-1:0]        o_top,
  output logic                   o_nonempty,
  output logic [PTR_W+CNT_W-1:0] o_ckpt
);
  logic [XLEN-1:0] r_stack [DEPTH];
  logic [PTR_W-1:0] r_tos, w_tos;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  assign w_tos = i_restore ? i_restore_ckpt[PTR_W+CNT_W-1:CNT_W] : r_tos;
  assign w_cnt = i_restore ? i_restore_ckpt[CNT_W-1:0] : r_cnt;
  assign o_top = r_stack[r_tos];
  assign o_nonempty = r_cnt != '0;
  assign o_ckpt = {r_tos, r_cnt};
  always_ff @(posedge clk)
    if (reset) begin
      r_tos <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_tos <= w_tos + 1'b1;
      r_cnt <= w_cnt == CNT_W'(DEPTH) ? w_cnt : w_cnt + 1'b1;
      r_stack[w_tos + 1'b1] <= i_push_addr;
    end else if (i_pop && w_cnt != '0) begin
      r_tos <= w_tos - 1'b1;
      r_cnt <= w_cnt - 1'b1;
    end else begin
      r_tos <= w_tos;
      r_cnt <= w_cnt;
    end
endmodule

// File: rtl/gshare_btb_predictor.sv
// gshare_btb_predictor: set-associative BTB, gshare PHT and speculative RAS fetch predictor
module gshare_btb_predictor
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN,
  parameter int BTB_SETS = 64,
  parameter int BTB_WAYS = 4,
  parameter int GHR_BITS = 8,
  parameter int PHT_ENTRIES = 1024,
  parameter int RAS_DEPTH = 8,
  localparam int SET_W = $clog2(BTB_SETS),
  localparam int WAY_W = $clog2(BTB_WAYS),
  localparam int PHT_W = $clog2(PHT_ENTRIES),
  localparam int TAG_W = XLEN - SET_W - 2,
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH),
  localparam int RAS_CKPT_W = RAS_PTR_W + $clog2(RAS_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  predict_req,
  input  logic [XLEN-1:0]       predict_pc,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic                  resp_taken,
  output logic [XLEN-1:0]       resp_target,
  output logic [GHR_BITS-1:0]   resp_ghr,
  output logic [RAS_CKPT_W-1:0] resp_ras_ckpt,
  input  logic                  update_en,
  input  logic [XLEN-1:0]       update_pc,
  input  logic                  update_taken,
  input  logic [XLEN-1:0]       update_target,
  input  br_type_t              update_br_type,
  input  logic [GHR_BITS-1:0]   update_ghr,
  input  logic [RAS_CKPT_W-1:0] update_ras_ckpt,
  input  logic                  update_mispredict,
  output logic [31:0]           stat_predictions,
  output logic [31:0]           stat_mispredictions
);
  logic r_valid [BTB_SETS][BTB_WAYS];
  logic [TAG_W-1:0] r_tag [BTB_SETS][BTB_WAYS];
  logic [XLEN-1:0] r_target [BTB_SETS][BTB_WAYS];
  br_type_t r_type [BTB_SETS][BTB_WAYS];
  logic [WAY_W-1:0] r_rr [BTB_SETS];
  ctr_t r_pht [PHT_ENTRIES];
  logic [GHR_BITS-1:0] r_ghr;
  logic [SET_W-1:0] w_p_set, w_u_set;
  logic [TAG_W-1:0] w_p_tag, w_u_tag;
  logic [PHT_W-1:0] w_p_idx, w_u_idx;
  logic [WAY_W-1:0] w_p_way, w_u_way, w_u_free, w_u_vic;
  logic w_p_hit, w_u_hit, w_u_inv, w_repair, w_acc, w_taken, w_push, w_pop, w_ras_ne, w_alloc, w_unused;
  br_type_t w_p_type;
  logic [XLEN-1:0] w_target, w_ras_top, w_push_addr;
  logic [RAS_CKPT_W-1:0] w_ras_ckpt;
  assign w_p_set = predict_pc[SET_W+1:2];
  assign w_u_set = update_pc[SET_W+1:2];
  assign w_p_tag = predict_pc[XLEN-1:SET_W+2];
  assign w_u_tag = update_pc[XLEN-1:SET_W+2];
  assign w_p_idx = predict_pc[PHT_W+1:2] ^ PHT_W'(r_ghr);
  assign w_u_idx = update_pc[PHT_W+1:2] ^ PHT_W'(update_ghr);
  assign w_unused = ^{predict_pc[1:0], update_pc[1:0]};
  always_comb begin
    w_p_hit = 1'b0;
    w_p_way = '0;
    w_u_hit = 1'b0;
    w_u_way = '0;
    w_u_inv = 1'b0;
    w_u_free = '0;
    for (int w = BTB_WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_p_set][w] && r_tag[w_p_set][w] == w_p_tag) begin
        w_p_hit = 1'b1;
        w_p_way = WAY_W'(w);
      end
      if (r_valid[w_u_set][w] && r_tag[w_u_set][w] == w_u_tag) begin
        w_u_hit = 1'b1;
        w_u_way = WAY_W'(w);
      end
      if (!r_valid[w_u_set][w]) begin
        w_u_inv = 1'b1;
        w_u_free = WAY_W'(w);
      end
    end
  end
  assign w_u_vic = w_u_inv ? w_u_free : r_rr[w_u_set];
  assign w_alloc = update_taken || update_br_type != COND;
  assign w_p_type = r_type[w_p_set][w_p_way];
  assign w_taken = w_p_hit && (w_p_type != COND || r_pht[w_p_idx][1]);
  assign w_target = !w_p_hit ? predict_pc + XLEN'(4)
                  : (w_p_type == RET && w_ras_ne) ? w_ras_top : r_target[w_p_set][w_p_way];
  assign w_repair = update_en && update_mispredict;
  assign w_acc = predict_req && !w_repair;
  assign w_push = w_repair ? update_br_type == CALL : w_acc && w_p_hit && w_p_type == CALL;
  assign w_pop = w_repair ? update_br_type == RET : w_acc && w_p_hit && w_p_type == RET;
  assign w_push_addr = (w_repair ? update_pc : predict_pc) + XLEN'(4);
  bp_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .reset(reset),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_restore(w_repair),
    .i_restore_ckpt(update_ras_ckpt),
    .i_push_addr(w_push_addr),
    .o_top(w_ras_top),
    .o_nonempty(w_ras_ne),
    .o_ckpt(w_ras_ckpt)
  );
  always_ff @(posedge clk)
    if (reset) begin
      for (int s = 0; s < BTB_SETS; s++) begin
        r_rr[s] <= '0;
        for (int w = 0; w < BTB_WAYS; w++) r_valid[s][w] <= 1'b0;
      end
      for (int i = 0; i < PHT_ENTRIES; i++) r_pht[i] <= WEAK_NT;
    end else if (update_en) begin
      if (update_br_type == COND) r_pht[w_u_idx] <= ctr_next(r_pht[w_u_idx], update_taken);
      if (w_u_hit) begin
        r_type[w_u_set][w_u_way] <= update_br_type;
        if (w_alloc) r_target[w_u_set][w_u_way] <= update_target;
      end else if (w_alloc) begin
        r_valid[w_u_set][w_u_vic] <= 1'b1;
        r_tag[w_u_set][w_u_vic] <= w_u_tag;
        r_target[w_u_set][w_u_vic] <= update_target;
        r_type[w_u_set][w_u_vic] <= update_br_type;
        if (!w_u_inv) r_rr[w_u_set] <= r_rr[w_u_set] + 1'b1;
      end
    end
  always_ff @(posedge clk)
    if (reset) begin
      r_ghr <= '0;
      resp_valid <= 1'b0;
      resp_hit <= 1'b0;
      resp_taken <= 1'b0;
      resp_target <= '0;
      resp_ghr <= '0;
      resp_ras_ckpt <= '0;
      stat_predictions <= '0;
      stat_mispredictions <= '0;
    end else begin
      r_ghr <= w_repair ? (update_br_type == COND ? {update_ghr[GHR_BITS-2:0], update_taken} : update_ghr)
             : (w_acc && w_p_hit && w_p_type == COND) ? {r_ghr[GHR_BITS-2:0], w_taken} : r_ghr;
      resp_valid <= w_acc;
      resp_hit <= w_p_hit;
      resp_taken <= w_taken;
      resp_target <= w_target;
      resp_ghr <= r_ghr;
      resp_ras_ckpt <= w_ras_ckpt;
      stat_predictions <= stat_predictions + 32'(w_acc);
      stat_mispredictions <= stat_mispredictions + 32'(w_repair);
    end
endmodule

// File: tb/tb_gshare_btb_predictor.sv
// tb_gshare_btb_predictor: directed plan steps plus random traffic against a behavioural predictor model
module tb_gshare_btb_predictor;
  import core_pkg::*;
  localparam int SETS = 64, WAYS = 4, PHT = 1024, DEPTH = 8;
  logic clk = 0, reset = 0, predict_req = 0, update_en = 0, update_taken = 0, update_mispredict = 0;
  logic [31:0] predict_pc = 0, update_pc = 0, update_target = 0;
  br_type_t update_br_type = COND;
  logic [7:0] update_ghr = 0;
  logic [6:0] update_ras_ckpt = 0;
  logic resp_valid, resp_hit, resp_taken;
  logic [31:0] resp_target, stat_predictions, stat_mispredictions;
  logic [7:0] resp_ghr;
  logic [6:0] resp_ras_ckpt;
  int n_tests = 0, n_fail = 0;
  logic m_v [SETS][WAYS];
  logic [31:0] m_tag [SETS][WAYS];
  logic [31:0] m_tgt [SETS][WAYS];
  br_type_t m_ty [SETS][WAYS];
  int m_rr [SETS];
  int m_pht [PHT];
  logic [31:0] m_ras [DEPTH];
  int m_ghr, m_tos, m_cnt, m_preds, m_mis;
  logic [7:0] ghr_hist = 0;
  logic [6:0] ck_hist = 0;
  gshare_btb_predictor dut (
    .clk(clk), .reset(reset), .predict_req(predict_req), .predict_pc(predict_pc),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_taken(resp_taken), .resp_target(resp_target),
    .resp_ghr(resp_ghr), .resp_ras_ckpt(resp_ras_ckpt), .update_en(update_en), .update_pc(update_pc),
    .update_taken(update_taken), .update_target(update_target), .update_br_type(update_br_type),
    .update_ghr(update_ghr), .update_ras_ckpt(update_ras_ckpt), .update_mispredict(update_mispredict),
    .stat_predictions(stat_predictions), .stat_mispredictions(stat_mispredictions)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int find(input logic [31:0] pc);
    int s = int'((pc >> 2) % SETS);
    int r = -1;
    for (int w = 0; w < WAYS; w++) if (r < 0 && m_v[s][w] && m_tag[s][w] == (pc >> 8)) r = w;
    return r;
  endfunction
  function automatic int pidx(input logic [31:0] pc, input int g);
    return int'((pc >> 2) % PHT) ^ g;
  endfunction
  task automatic push(input logic [31:0] a);
    m_tos = (m_tos + 1) % DEPTH;
    m_ras[m_tos] = a;
    if (m_cnt < DEPTH) m_cnt++;
  endtask
  task automatic pop();
    if (m_cnt > 0) begin
      m_tos = (m_tos + DEPTH - 1) % DEPTH;
      m_cnt--;
    end
  endtask
  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_v[s][w] = 0;
    end
    for (int i = 0; i < PHT; i++) m_pht[i] = 1;
    m_ghr = 0; m_tos = 0; m_cnt = 0; m_preds = 0; m_mis = 0;
  endtask
  task automatic train();
    int s = int'((update_pc >> 2) % SETS);
    int w = find(update_pc);
    int v = -1;
    int i;
    if (update_br_type == COND) begin
      i = pidx(update_pc, int'(update_ghr));
      m_pht[i] = update_taken ? (m_pht[i] < 3 ? m_pht[i] + 1 : 3) : (m_pht[i] > 0 ? m_pht[i] - 1 : 0);
    end
    if (w >= 0) begin
      m_ty[s][w] = update_br_type;
      if (update_taken || update_br_type != COND) m_tgt[s][w] = update_target;
    end else if (update_taken || update_br_type != COND) begin
      for (int k = 0; k < WAYS; k++) if (v < 0 && !m_v[s][k]) v = k;
      if (v < 0) begin
        v = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % WAYS;
      end
      m_v[s][v] = 1; m_tag[s][v] = update_pc >> 8; m_tgt[s][v] = update_target; m_ty[s][v] = update_br_type;
    end
  endtask
  task automatic step();
    logic rep, ev, eh, et;
    logic [31:0] etg;
    logic [7:0] eg;
    logic [6:0] ec;
    int w, s;
    br_type_t ty;
    rep = update_en && update_mispredict;
    ev = predict_req && !rep;
    w = find(predict_pc);
    s = int'((predict_pc >> 2) % SETS);
    eh = w >= 0;
    eg = m_ghr[7:0];
    ec = {m_tos[2:0], m_cnt[3:0]};
    et = 0; etg = predict_pc + 4; ty = COND;
    if (eh) begin
      ty = m_ty[s][w];
      et = ty != COND || m_pht[pidx(predict_pc, m_ghr)] >= 2;
      etg = (ty == RET && m_cnt > 0) ? m_ras[m_tos] : m_tgt[s][w];
    end
    if (update_en) train();
    if (rep) begin
      m_ghr = update_br_type == COND ? ((int'(update_ghr) << 1) | int'(update_taken)) & 255 : int'(update_ghr);
      m_tos = int'(update_ras_ckpt[6:4]);
      m_cnt = int'(update_ras_ckpt[3:0]);
      if (update_br_type == CALL) push(update_pc + 4);
      if (update_br_type == RET) pop();
      m_mis++;
    end else if (ev && eh) begin
      if (ty == COND) m_ghr = ((m_ghr << 1) | int'(et)) & 255;
      if (ty == CALL) push(predict_pc + 4);
      if (ty == RET) pop();
    end
    if (ev) begin
      m_preds++;
      ghr_hist = eg;
      ck_hist = ec;
    end
    @(posedge clk); #1;
    chk("resp_valid", resp_valid, ev);
    if (ev) begin
      chk("resp_hit", resp_hit, eh);
      chk("resp_taken", resp_taken, et);
      chk("resp_target", resp_target, etg);
      chk("resp_ghr", resp_ghr, eg);
      chk("resp_ras_ckpt", resp_ras_ckpt, ec);
    end
    chk("stat_predictions", stat_predictions, m_preds);
    chk("stat_mispredictions", stat_mispredictions, m_mis);
    predict_req = 0; update_en = 0; update_mispredict = 0;
  endtask
  task automatic req(input logic [31:0] pc);
    predict_req = 1;
    predict_pc = pc;
  endtask
  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input br_type_t ty,
                     input logic [7:0] g, input logic [6:0] ck, input logic mis);
    update_en = 1; update_pc = pc; update_taken = t; update_target = tgt; update_br_type = ty;
    update_ghr = g; update_ras_ckpt = ck; update_mispredict = mis;
  endtask
  task automatic do_reset();
    reset = 1; update_en = 0; update_mispredict = 0;
    req(32'h100);
    model_reset();
    @(posedge clk); #1; @(posedge clk); #1;
    reset = 0; predict_req = 0;
    chk("rst_valid", resp_valid, 0);
    chk("rst_hit", resp_hit, 0);
    chk("rst_taken", resp_taken, 0);
    chk("rst_target", resp_target, 0);
    chk("rst_ghr", resp_ghr, 0);
    chk("rst_ckpt", resp_ras_ckpt, 0);
    chk("rst_stat_pred", stat_predictions, 0);
    chk("rst_stat_mis", stat_mispredictions, 0);
  endtask
  function automatic logic [31:0] rpc();
    return 32'h10000 + ($urandom_range(0, 5) << 8) + ($urandom_range(0, 3) << 2);
  endfunction
  initial begin
    do_reset();
    req(32'h100); step();
    chk("plan_miss_hit", resp_hit, 0);
    chk("plan_miss_target", resp_target, 32'h104);
    upd(32'h200, 1, 32'h300, COND, 0, 0, 0); step();
    upd(32'h200, 1, 32'h300, COND, 0, 0, 0); step();
    req(32'h200); step();
    chk("plan_cond_taken", resp_taken, 1);
    chk("plan_cond_target", resp_target, 32'h300);
    req(32'h100); step();
    chk("plan_ghr_after", resp_ghr, 8'h01);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      upd(32'h1000 + 32'(i) * 32'h100, 1, 32'h8000 + 32'(i) * 16, UNCOND, 0, 0, 0); step();
    end
    req(32'h1000); step();
    chk("plan_evicted", resp_hit, 0);
    req(32'h1100); step();
    chk("plan_kept", resp_hit, 1);
    req(32'h1400); step();
    chk("plan_newest", resp_target, 32'h8040);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      upd(32'h2000 + 32'(i) * 4, 1, 32'h5000, CALL, 0, 0, 0); step();
    end
    upd(32'h3000, 1, 32'h7770, RET, 0, 0, 0); step();
    for (int i = 0; i < 9; i++) begin
      req(32'h2000 + 32'(i) * 4); step();
    end
    for (int k = 0; k < 9; k++) begin
      req(32'h3000); step();
      chk("plan_ret_target", resp_target, k < 8 ? 32'h2000 + 32'(8 - k) * 4 + 4 : 32'h7770);
    end
    do_reset();
    upd(32'h600, 1, 32'h640, COND, 8'h05, 0, 0); step();
    upd(32'h600, 1, 32'h640, COND, 8'h05, 0, 0); step();
    upd(32'h700, 1, 32'h900, UNCOND, 8'h05, 0, 1); step();
    req(32'h600); step();
    chk("plan_ghr_ckpt", resp_ghr, 8'h05);
    upd(32'h600, 0, 32'h640, COND, 8'h05, 0, 1); req(32'h600); step();
    chk("plan_drop", resp_valid, 0);
    req(32'h100); step();
    chk("plan_ghr_repair", resp_ghr, 8'h0A);
    do_reset();
    upd(32'h400, 1, 32'h480, UNCOND, 0, 0, 0); req(32'h400); step();
    chk("plan_rbw_miss", resp_hit, 0);
    req(32'h400); step();
    chk("plan_rbw_hit", resp_target, 32'h480);
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) != 0) req(rpc());
      if ($urandom_range(0, 1) == 0)
        upd(rpc(), 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, br_type_t'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0 ? 8'($urandom) : ghr_hist, ck_hist, $urandom_range(0, 5) == 0);
      step();
      if (n == 700) do_reset();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
